// File: rtl/varint_writer_pkg.sv
// Shared definitions for the varint writer: protobuf field-type codes, request record, port geometry.
package varint_writer_pkg;

    localparam int LANES     = 8;
    localparam int MAX_BYTES = 10;

    typedef enum logic [4:0] {
        FT_DOUBLE   = 5'd1,
        FT_FLOAT    = 5'd2,
        FT_INT64    = 5'd3,
        FT_UINT64   = 5'd4,
        FT_INT32    = 5'd5,
        FT_FIXED64  = 5'd6,
        FT_FIXED32  = 5'd7,
        FT_BOOL     = 5'd8,
        FT_STRING   = 5'd9,
        FT_GROUP    = 5'd10,
        FT_MESSAGE  = 5'd11,
        FT_BYTES    = 5'd12,
        FT_UINT32   = 5'd13,
        FT_ENUM     = 5'd14,
        FT_SFIXED32 = 5'd15,
        FT_SFIXED64 = 5'd16,
        FT_SINT32   = 5'd17,
        FT_SINT64   = 5'd18
    } field_type_e;

    typedef struct packed {
        logic [63:0] value;
        logic [63:0] dst_addr;
        logic [4:0]  field_type;
    } TABLE_ENTRY;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE0,
        ST_WRITE1,
        ST_DONE
    } state_e;

    function automatic logic [63:0] zigzag64(input logic [63:0] v);
        return {v[62:0], 1'b0} ^ {64{v[63]}};
    endfunction

endpackage

// File: rtl/varint_writer_encode.sv
// Combinational varint encoder: selects the operand by field type and splits it into 7-bit groups.
module varint_encode
    import varint_writer_pkg::*;
(
    input  logic [63:0]                 value,
    input  logic [4:0]                  field_type,
    output logic [MAX_BYTES-1:0][7:0]   bytes,
    output logic [3:0]                  n
);

    logic [63:0] operand;
    logic [31:0] zz32;
    logic [69:0] op_ext;

    always_comb begin
        zz32 = {value[30:0], 1'b0} ^ {32{value[31]}};
        case (field_type)
            FT_SINT32:         operand = {32'b0, zz32};
            FT_SINT64:         operand = zigzag64(value);
            FT_INT32, FT_ENUM: operand = {{32{value[31]}}, value[31:0]};
            FT_UINT32:         operand = {32'b0, value[31:0]};
            FT_BOOL:           operand = {63'b0, |value[7:0]};
            default:           operand = value;
        endcase
    end

    // Length is one past the highest non-empty group; zero still takes one byte.
    always_comb begin
        op_ext = {6'b0, operand};
        n = 4'd1;
        for (int i = 1; i < MAX_BYTES; i++) begin
            if (|op_ext[7*i +: 7]) n = 4'(i + 1);
        end
        for (int i = 0; i < MAX_BYTES; i++) begin
            bytes[i] = {(4'(i + 1) < n), op_ext[7*i +: 7]};
        end
    end

endmodule

// File: rtl/varint_writer.sv
// Varint writer: encodes one scalar on an en rising edge and writes it ending at dst_addr in one or two beats.
module varint_writer
    import varint_writer_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic [63:0]             dst_addr,
    input  logic [63:0]             value,
    input  logic [4:0]              field_type,
    output logic [LANES-1:0]        dram_en,
    output logic [LANES-1:0][63:0]  dram_addr,
    output logic [LANES-1:0][7:0]   dram_data,
    output logic                    dram_rdwr,
    output logic                    done,
    output logic [3:0]              bytes_written
);

    state_e                    state, state_nxt;
    logic                      en_q;
    logic                      start;
    TABLE_ENTRY                req, enc_req;
    logic [MAX_BYTES-1:0][7:0] enc_bytes;
    logic [15:0][7:0]          bytes_pad;
    logic [3:0]                enc_n;
    logic [63:0]               base;
    logic                      beat1, active;
    logic [3:0]                idx;

    logic [LANES-1:0]          en_nxt;
    logic [LANES-1:0][63:0]    addr_nxt;
    logic [LANES-1:0][7:0]     data_nxt;
    logic                      done_nxt;
    logic [3:0]                bw_nxt;

    assign start = en & ~en_q & (state == ST_IDLE);

    // Beat 0 is registered on the start edge, so the encoder sees live inputs while idle.
    always_comb begin
        if (state == ST_IDLE) begin
            enc_req = '{value: value, dst_addr: dst_addr, field_type: field_type};
        end else begin
            enc_req = req;
        end
    end

    varint_encode u_encode (
        .value      (enc_req.value),
        .field_type (enc_req.field_type),
        .bytes      (enc_bytes),
        .n          (enc_n)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            en_q  <= 1'b0;
            req   <= '0;
        end else begin
            state <= state_nxt;
            en_q  <= en;
            if (start) req <= enc_req;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (start) state_nxt = ST_WRITE0;
            ST_WRITE0: state_nxt = (enc_n > 4'd8) ? ST_WRITE1 : ST_DONE;
            ST_WRITE1: state_nxt = ST_DONE;
            ST_DONE:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        bytes_pad = {48'b0, enc_bytes};
        base      = enc_req.dst_addr - 64'(enc_n) + 64'd1;
        beat1     = (state_nxt == ST_WRITE1);
        active    = (state_nxt == ST_WRITE0) || beat1;
        idx       = 4'd0;
        for (int i = 0; i < LANES; i++) begin
            idx         = {beat1, 3'b000} + 4'(i);
            en_nxt[i]   = active && (idx < enc_n);
            addr_nxt[i] = en_nxt[i] ? base + 64'(idx) : dram_addr[i];
            data_nxt[i] = en_nxt[i] ? bytes_pad[idx] : dram_data[i];
        end
        done_nxt = (state_nxt == ST_DONE);
        bw_nxt   = done_nxt ? enc_n : bytes_written;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dram_en       <= '0;
            dram_addr     <= '0;
            dram_data     <= '0;
            dram_rdwr     <= 1'b0;
            done          <= 1'b0;
            bytes_written <= 4'd0;
        end else begin
            dram_en       <= en_nxt;
            dram_addr     <= addr_nxt;
            dram_data     <= data_nxt;
            dram_rdwr     <= |en_nxt;
            done          <= done_nxt;
            bytes_written <= bw_nxt;
        end
    end

endmodule

// File: tb/tb_varint_writer.sv
// Directed bench for varint_writer: vector table plus hand-written reset/en-edge sequences.
module tb_varint_writer;

    logic             clk = 1'b0;
    logic             reset;
    logic             en;
    logic [63:0]      dst_addr;
    logic [63:0]      value;
    logic [4:0]       field_type;
    logic [7:0]       dram_en;
    logic [7:0][63:0] dram_addr;
    logic [7:0][7:0]  dram_data;
    logic             dram_rdwr;
    logic             done;
    logic [3:0]       bytes_written;

    varint_writer dut (
        .clk           (clk),
        .reset         (reset),
        .en            (en),
        .dst_addr      (dst_addr),
        .value         (value),
        .field_type    (field_type),
        .dram_en       (dram_en),
        .dram_addr     (dram_addr),
        .dram_data     (dram_data),
        .dram_rdwr     (dram_rdwr),
        .done          (done),
        .bytes_written (bytes_written)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  ft;
        logic [63:0] val;
        logic [63:0] dst;
        int          n;
        logic [79:0] bytes;   // byte i at [8i +: 8]
    } vec_t;

    vec_t  vecs[13];
    int    total = 0;
    int    bad   = 0;
    string tag   = "";

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s/%s: got %0h expected %0h", tag, name, act, exp);
        end
    endtask

    task automatic check_beat(input vec_t v, input int beat);
        logic [63:0] base;
        logic [7:0]  mask;
        int          idx;
        base = v.dst - 64'(v.n) + 64'd1;
        for (int i = 0; i < 8; i++) mask[i] = (beat * 8 + i) < v.n;
        check($sformatf("beat%0d_en", beat), 64'(dram_en), 64'(mask));
        check($sformatf("beat%0d_rdwr", beat), 64'(dram_rdwr), 64'd1);
        check($sformatf("beat%0d_done", beat), 64'(done), 64'd0);
        for (int i = 0; i < 8; i++) begin
            idx = beat * 8 + i;
            if (mask[i]) begin
                check($sformatf("addr%0d", idx), dram_addr[i], base + 64'(idx));
                check($sformatf("data%0d", idx), 64'(dram_data[i]), 64'(v.bytes[8*idx +: 8]));
            end
        end
    endtask

    task automatic apply(input vec_t v);
        field_type = v.ft;
        value      = v.val;
        dst_addr   = v.dst;
    endtask

    task automatic run_vec(input vec_t v);
        @(negedge clk);
        apply(v);
        en = 1'b1;
        @(negedge clk);
        check_beat(v, 0);
        if (v.n > 8) begin
            @(negedge clk);
            check_beat(v, 1);
        end
        @(negedge clk);
        check("done", 64'(done), 64'd1);
        check("done_en", 64'(dram_en), 64'd0);
        check("done_rdwr", 64'(dram_rdwr), 64'd0);
        check("bytes_written", 64'(bytes_written), 64'(v.n));
        en = 1'b0;
        @(negedge clk);
        check("idle_done", 64'(done), 64'd0);
        check("idle_en", 64'(dram_en), 64'd0);
        check("bw_held", 64'(bytes_written), 64'(v.n));
    endtask

    initial begin
        int done_cnt;
        int beat_cnt;

        vecs[0]  = '{5'd4,  64'd1,                   64'h1000, 1,  80'h01};
        vecs[1]  = '{5'd4,  64'd300,                 64'h1000, 2,  80'h02AC};
        vecs[2]  = '{5'd17, 64'hFFFF_FFFF,           64'h3000, 1,  80'h01};
        vecs[3]  = '{5'd17, 64'd1,                   64'h3000, 1,  80'h02};
        vecs[4]  = '{5'd5,  64'hFFFF_FFFF,           64'h2009, 10, 80'h01_FFFF_FFFF_FFFF_FFFF_FF};
        vecs[5]  = '{5'd4,  64'd0,                   64'h1234, 1,  80'h00};
        vecs[6]  = '{5'd18, 64'h8000_0000_0000_0000, 64'h5,    10, 80'h01_FFFF_FFFF_FFFF_FFFF_FF};
        vecs[7]  = '{5'd8,  64'h100,                 64'h40,   1,  80'h00};
        vecs[8]  = '{5'd13, 64'hFFFF_FFFF_FFFF_FFFF, 64'h4004, 5,  80'h0F_FFFF_FFFF};
        vecs[9]  = '{5'd14, 64'hFFFF_FFFF_0000_0080, 64'h7001, 2,  80'h0180};
        vecs[10] = '{5'd4,  64'h00FF_FFFF_FFFF_FFFF, 64'h8007, 8,  80'h7F_FFFF_FFFF_FFFF_FF};
        vecs[11] = '{5'd4,  64'h0100_0000_0000_0000, 64'h9008, 9,  80'h01_8080_8080_8080_8080};
        vecs[12] = '{5'd3,  64'h7F,                  64'hA000, 1,  80'h7F};

        reset = 1'b1;
        en = 1'b0;
        apply(vecs[0]);
        repeat (3) @(posedge clk);
        @(negedge clk);
        tag = "reset";
        check("en", 64'(dram_en), 64'd0);
        check("rdwr", 64'(dram_rdwr), 64'd0);
        check("done", 64'(done), 64'd0);
        check("bw", 64'(bytes_written), 64'd0);
        check("addr0", dram_addr[0], 64'd0);
        check("data0", 64'(dram_data[0]), 64'd0);
        reset = 1'b0;

        for (int k = 0; k < 13; k++) begin
            tag = $sformatf("vec%0d", k);
            run_vec(vecs[k]);
        end

        // en held high: exactly one operation.
        tag = "held";
        done_cnt = 0;
        beat_cnt = 0;
        @(negedge clk);
        apply(vecs[1]);
        en = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (done) done_cnt++;
            if (dram_en != 8'h00) beat_cnt++;
        end
        check("done_pulses", 64'(done_cnt), 64'd1);
        check("beats", 64'(beat_cnt), 64'd1);
        check("bw", 64'(bytes_written), 64'd2);
        en = 1'b0;

        // en dropped mid-operation, re-raised during DONE: completes once, re-edge ignored.
        tag = "redge";
        @(negedge clk);
        apply(vecs[4]);
        en = 1'b1;
        @(negedge clk);
        check_beat(vecs[4], 0);
        en = 1'b0;
        @(negedge clk);
        check_beat(vecs[4], 1);
        @(negedge clk);
        check("done", 64'(done), 64'd1);
        apply(vecs[0]);
        en = 1'b1;
        beat_cnt = 0;
        done_cnt = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (done) done_cnt++;
            if (dram_en != 8'h00) beat_cnt++;
        end
        check("no_restart_beats", 64'(beat_cnt), 64'd0);
        check("no_restart_done", 64'(done_cnt), 64'd0);
        check("bw", 64'(bytes_written), 64'd10);
        en = 1'b0;

        // Reset during beat 0 of a 10-byte write aborts it.
        tag = "abort";
        @(negedge clk);
        apply(vecs[4]);
        en = 1'b1;
        @(negedge clk);
        check_beat(vecs[4], 0);
        reset = 1'b1;
        en = 1'b0;
        @(negedge clk);
        check("en", 64'(dram_en), 64'd0);
        check("done", 64'(done), 64'd0);
        reset = 1'b0;
        beat_cnt = 0;
        done_cnt = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (done) done_cnt++;
            if (dram_en != 8'h00) beat_cnt++;
        end
        check("post_beats", 64'(beat_cnt), 64'd0);
        check("post_done", 64'(done_cnt), 64'd0);
        tag = "after_abort";
        run_vec(vecs[4]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/varint_writer.md
# varint_writer

Sequential protobuf varint serializer for the serialization engine. On a start request it encodes one 64-bit scalar as a base-128 varint and writes the bytes to DRAM over the 8-lane byte port. The bytes end at a given address, because the message buffer is filled from high to low addresses. It then reports the byte count so the caller can move its write pointer down and place the field header below the value.

## Interface
- No parameters.
- Reset and clock: reset is synchronous and active-high; the clock is clk.
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- en  in  1  start request; level input, acted on at its rising edge only
- dst_addr  in  64  address of the last (most significant) encoded byte
- value  in  64  raw value loaded from the source object
- field_type  in  5  protobuf descriptor type code
- dram_en  out  8  per-lane byte enable
- dram_addr  out  8×64  per-lane byte address
- dram_data  out  8×8  per-lane write data
- dram_rdwr  out  1  1 = write; held 1 while any lane is enabled
- done  out  1  one-cycle completion pulse
- bytes_written  out  4  encoded length n (1..10); valid from the done pulse until the next start

## Operation
- Start condition: en=1 and en_q=0, where en_q is the registered previous en (reset 0). Start is honoured only in IDLE.
- At start, value, dst_addr and field_type are captured into registers.
- Operand selection by field_type:
  - 17 (sint32): zigzag of the low 32 bits, (v<<1)^(v>>>31), zero-extended.
  - 18 (sint64): zigzag over 64 bits.
  - 5 (int32), 14 (enum): low 32 bits sign-extended to 64, so a negative value encodes as 10 bytes.
  - 13 (uint32): low 32 bits zero-extended.
  - 8 (bool): 1 if value[7:0]≠0, else 0.
  - All other codes: the full 64-bit value.
- Encoding:
  - Byte i carries operand bits [7i+6:7i].
  - Bit 7 of every byte is 1 except the last byte.
  - n = max(1, ceil(bitlen/7)), so operand 0 gives one byte 0x00.
- Placement:
  - base = dst_addr − n + 1 (64-bit wrap).
  - Byte i goes to address base+i, so the lowest-order group sits at the lowest address.
- Beat 0: lane i carries byte i at address base+i. dram_en has the low min(n,8) bits set.
- Beat 1 (only when n>8): lane i carries byte 8+i at address base+8+i. dram_en has the low n−8 bits set (0x01 or 0x03).
- Disabled lanes: dram_addr and dram_data hold their previous values. Only enabled lanes are meaningful.
- States:
  - IDLE: on start → WRITE0.
  - WRITE0: → WRITE1 if n>8, else → DONE.
  - WRITE1: → DONE.
  - DONE: → IDLE.
- done=1 only in the DONE cycle. dram_en=0 in IDLE and DONE.

## Timing
- Reset values: all outputs 0, state IDLE, en_q 0.
- Reset during an operation aborts it. The next cycle has dram_en=0 and done=0.
- All outputs are registered.
- en rises in cycle k:
  - Beat 0 is on the port in cycle k+1.
  - If n≤8, done pulses in cycle k+2.
  - If n>8, beat 1 is in cycle k+2 and done pulses in cycle k+3.
- Dropping en mid-operation does not abort it.
- A new rising edge of en while busy is ignored. A new rising edge of en in the DONE cycle is also ignored: it is not queued, and the caller must toggle en again.
- en held high after completion does not restart the block.

## Structure
- Shared package holds:
  - Field-type codes, with names for 1–18.
  - The TABLE_ENTRY typedef.
  - DRAM port lane count (8).
- Sub-module varint_encode: purely combinational. Maps {value, field_type} to {bytes[9:0][7:0], n}.
- The sequencing FSM stays in varint_writer.

## Test plan
- type 4, value 1, dst 0x1000 → cycle k+1: dram_en=0x01, addr[0]=0x1000, data[0]=0x01, rdwr=1 → done at k+2 with bytes_written=1.
- type 4, value 300, dst 0x1000 → dram_en=0x03, lanes 0/1 at 0xFFF/0x1000 carry 0xAC/0x02 → bytes_written=2.
- type 17, value 0xFFFFFFFF → operand 1, single byte 0x01. type 17, value 1 → single byte 0x02.
- type 5, value 0xFFFFFFFF, dst 0x2009:
  - Beat 0: dram_en=0xFF, addresses 0x2000..0x2007, data 0xFF×8.
  - Beat 1: dram_en=0x03, data 0xFF, 0x01.
  - done at k+3 with bytes_written=10.
- type 4, value 0 → one byte 0x00. en held high for 5 cycles → exactly one operation.
- Assert reset during beat 0 of a 10-byte write → no beat 1, no done pulse. Then a fresh en rising edge → normal operation.
